// File: rtl/riscv_lsu.sv
// Load-store unit: registers core data requests, drives word-aligned memory accesses with byte enables, and extends load data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (blocks misaligned H/HU/W accesses and raises core_misalign_o).
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      state_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [3:0]  mem_be_r;
    logic [29:0] word_addr_r;
    logic [31:0] mem_wd_r;
    logic [2:0]  size_r;
    logic [1:0]  off_r;
    logic [31:0] rd_hold_r;

    logic [3:0]  be_s;
    logic [31:0] wd_s;
    logic        misalign_addr_s;
    logic        misalign_s;
    logic        issue_s;
    logic        done_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] rd_ext_s;

    // Request decode: size[1:0] selects B/H/W, so undefined sizes 3, 6 and 7 fall through to W.
    always_comb begin
        be_s            = 4'b1111;
        wd_s            = core_wd_i;
        misalign_addr_s = 1'b0;
        case (core_size_i[1:0])
            2'b00: begin
                be_s            = 4'b0001 << core_addr_i[1:0];
                wd_s            = {4{core_wd_i[7:0]}};
                misalign_addr_s = 1'b0;
            end
            2'b01: begin
                be_s            = 4'b0011 << {core_addr_i[1], 1'b0};
                wd_s            = {2{core_wd_i[15:0]}};
                misalign_addr_s = core_addr_i[0];
            end
            default: begin
                be_s            = 4'b1111;
                wd_s            = core_wd_i;
                misalign_addr_s = (core_addr_i[1:0] != 2'b00);
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = (state_r == ST_IDLE) & core_req_i & misalign_addr_s;
`else
    logic unused_misalign_s;
    assign unused_misalign_s = misalign_addr_s;
    assign misalign_s        = 1'b0;
`endif

    assign issue_s = (state_r == ST_IDLE) & core_req_i & ~misalign_s;
    assign done_s  = (state_r == ST_ACCESS) & mem_ready_i;

    // Load extraction from the returned word using the offset captured at issue.
    always_comb begin
        case (off_r)
            2'd0:    byte_s = mem_rd_i[7:0];
            2'd1:    byte_s = mem_rd_i[15:8];
            2'd2:    byte_s = mem_rd_i[23:16];
            default: byte_s = mem_rd_i[31:24];
        endcase
        if (off_r[1]) begin
            half_s = mem_rd_i[31:16];
        end else begin
            half_s = mem_rd_i[15:0];
        end
        case (size_r[1:0])
            2'b00:   rd_ext_s = {{24{byte_s[7] & ~size_r[2]}}, byte_s};
            2'b01:   rd_ext_s = {{16{half_s[15] & ~size_r[2]}}, half_s};
            default: rd_ext_s = mem_rd_i;
        endcase
    end

    // Access FSM with capture registers; reset drops any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            word_addr_r <= 30'd0;
            mem_wd_r    <= 32'd0;
            size_r      <= 3'd0;
            off_r       <= 2'd0;
            rd_hold_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_r     <= ST_ACCESS;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= core_we_i;
                        mem_be_r    <= be_s;
                        word_addr_r <= core_addr_i[31:2];
                        mem_wd_r    <= wd_s;
                        size_r      <= core_size_i;
                        off_r       <= core_addr_i[1:0];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready_i) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (!mem_we_r) begin
                            rd_hold_r <= rd_ext_s;
                        end else begin
                            rd_hold_r <= rd_hold_r;
                        end
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o       = mem_req_r;
    assign mem_we_o        = mem_we_r;
    assign mem_be_o        = mem_be_r;
    assign mem_addr_o      = {word_addr_r, 2'b00};
    assign mem_wd_o        = mem_wd_r;
    assign core_misalign_o = misalign_s;
    assign core_stall_o    = core_req_i & ~done_s & ~misalign_s;
    assign core_rd_o       = (done_s & ~mem_we_r) ? rd_ext_s : rd_hold_r;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed vector table, hand-written reset/misalign sequences, and random
// transactions checked against an arithmetic reference model.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] hold_exp = 32'd0;

    riscv_lsu dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;
        logic        gap;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: number of bytes and lane offset from the access size, plain arithmetic.
    task automatic model(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, output logic [3:0] be, output logic [31:0] maddr,
                         output logic [31:0] mwd, output logic [31:0] rd);
        int n;
        int off;
        logic [31:0] v;
        n = (size == 3'd0 || size == 3'd4) ? 1 : (size == 3'd1 || size == 3'd5) ? 2 : 4;
        off = (n == 4) ? 0 : (n == 2) ? int'(addr & 32'd2) : int'(addr % 32'd4);
        be = 4'(((1 << n) - 1) << off);
        maddr = addr - (addr % 32'd4);
        for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wd[8*(i % n) +: 8];
        v = rdata >> (8 * off);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (size < 3'd4 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'h0000_FFFF;
            if (size < 3'd4 && v[15]) v = v | 32'hFFFF_0000;
        end
        rd = v;
    endtask

    task automatic do_txn(input vec_t t);
        core_req_i  = 1'b1;
        core_we_i   = t.we;
        core_size_i = t.size;
        core_addr_i = t.addr;
        core_wd_i   = t.wd;
        mem_ready_i = 1'b0;
        mem_rd_i    = $urandom;
        @(negedge clk_i);
        chk("issue_stall", {31'd0, core_stall_o}, 32'd1);
        chk("issue_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("issue_misalign", {31'd0, core_misalign_o}, 32'd0);
        next_cycle();
        for (int k = 0; k <= t.delay; k++) begin
            mem_ready_i = (k == t.delay);
            mem_rd_i    = (k == t.delay) ? t.rdata : $urandom;
            @(negedge clk_i);
            chk("acc_mem_req", {31'd0, mem_req_o}, 32'd1);
            chk("acc_mem_we", {31'd0, mem_we_o}, {31'd0, t.we});
            chk("acc_mem_addr", mem_addr_o, t.maddr);
            chk("acc_mem_be", {28'd0, mem_be_o}, {28'd0, t.be});
            if (t.we) chk("acc_mem_wd", mem_wd_o, t.mwd);
            chk("acc_stall", {31'd0, core_stall_o}, (k == t.delay) ? 32'd0 : 32'd1);
            if (k == t.delay && !t.we) chk("load_rd", core_rd_o, t.rd);
            next_cycle();
        end
        if (!t.we) hold_exp = t.rd;
        mem_ready_i = 1'b0;
        if (t.gap) begin
            core_req_i = 1'b0;
            @(negedge clk_i);
            chk("post_mem_req", {31'd0, mem_req_o}, 32'd0);
            chk("post_stall", {31'd0, core_stall_o}, 32'd0);
            chk("post_rd_hold", core_rd_o, hold_exp);
            next_cycle();
        end
    endtask

    initial begin
        vec_t r;
        rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = 32'd0; core_wd_i = 32'd0; mem_rd_i = 32'd0; mem_ready_i = 1'b0;

        //          we    size  addr           wd             rdata          dly gap   be        maddr          mwd            rd
        tbl[0]  = '{1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 1'b0, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0,         0, 1'b1, 4'b1000, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0};
        tbl[2]  = '{1'b0, 3'd0, 32'h0000_0102, 32'h0,         32'h12F0_3456, 0, 1'b1, 4'b0100, 32'h0000_0100, 32'h0,         32'hFFFF_FFF0};
        tbl[3]  = '{1'b0, 3'd4, 32'h0000_0102, 32'h0,         32'h12F0_3456, 0, 1'b1, 4'b0100, 32'h0000_0100, 32'h0,         32'h0000_00F0};
        tbl[4]  = '{1'b0, 3'd1, 32'h0000_0202, 32'h0,         32'h8001_0000, 3, 1'b1, 4'b1100, 32'h0000_0200, 32'h0,         32'hFFFF_8001};
        tbl[5]  = '{1'b0, 3'd5, 32'h0000_0200, 32'h0,         32'h1234_ABCD, 1, 1'b1, 4'b0011, 32'h0000_0200, 32'h0,         32'h0000_ABCD};
        tbl[6]  = '{1'b1, 3'd1, 32'h0000_0106, 32'h0000_BEEF, 32'h0,         1, 1'b1, 4'b1100, 32'h0000_0104, 32'hBEEF_BEEF, 32'h0};
        tbl[7]  = '{1'b0, 3'd2, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 2, 1'b1, 4'b1111, 32'h0000_0300, 32'h0,         32'hCAFE_F00D};
        tbl[8]  = '{1'b0, 3'd3, 32'h0000_0400, 32'h0,         32'h89AB_CDEF, 0, 1'b1, 4'b1111, 32'h0000_0400, 32'h0,         32'h89AB_CDEF};
        tbl[9]  = '{1'b1, 3'd6, 32'h0000_0404, 32'h1122_3344, 32'h0,         0, 1'b1, 4'b1111, 32'h0000_0404, 32'h1122_3344, 32'h0};
        tbl[10] = '{1'b0, 3'd0, 32'h0000_0001, 32'h0,         32'h0000_8000, 0, 1'b0, 4'b0010, 32'h0000_0000, 32'h0,         32'hFFFF_FF80};
        tbl[11] = '{1'b0, 3'd4, 32'h0000_0003, 32'h0,         32'h7F00_0000, 0, 1'b1, 4'b1000, 32'h0000_0000, 32'h0,         32'h0000_007F};

        // Reset state with no request
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wd", mem_wd_o, 32'd0);
        chk("rst_core_rd", core_rd_o, 32'd0);
        chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("rst_misalign", {31'd0, core_misalign_o}, 32'd0);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();

        for (int i = 0; i < 12; i++) do_txn(tbl[i]);

        // Reset in the second ACCESS cycle of an LH discards the access
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd1;
        core_addr_i = 32'h0000_0202; mem_ready_i = 1'b0; mem_rd_i = 32'h8001_0000;
        next_cycle();
        @(negedge clk_i);
        chk("rstacc_req1", {31'd0, mem_req_o}, 32'd1);
        chk("rstacc_stall1", {31'd0, core_stall_o}, 32'd1);
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstacc_req2", {31'd0, mem_req_o}, 32'd1);
        next_cycle();
        rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b1;
        hold_exp = 32'd0;
        @(negedge clk_i);
        chk("rstacc_req_after", {31'd0, mem_req_o}, 32'd0);
        chk("rstacc_be_after", {28'd0, mem_be_o}, 32'd0);
        chk("rstacc_stall_after", {31'd0, core_stall_o}, 32'd0);
        chk("rstacc_rd_after", core_rd_o, 32'd0);
        next_cycle();
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ready_ignored", {31'd0, mem_req_o}, 32'd0);
        chk("idle_ready_rd", core_rd_o, 32'd0);
        next_cycle();

        // LW at a misaligned address
`ifdef LSU_MISALIGN_TRAP_EN
        do_txn('{1'b0, 3'd4, 32'h0000_0010, 32'h0, 32'h0000_005A, 0, 1'b1, 4'b0001, 32'h0000_0010, 32'h0, 32'h0000_005A});
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h0000_0102;
        mem_rd_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        chk("mis_flag", {31'd0, core_misalign_o}, 32'd1);
        chk("mis_stall", {31'd0, core_stall_o}, 32'd0);
        chk("mis_rd", core_rd_o, hold_exp);
        next_cycle();
        core_req_i = 1'b0;
        @(negedge clk_i);
        chk("mis_no_req", {31'd0, mem_req_o}, 32'd0);
        chk("mis_rd_after", core_rd_o, hold_exp);
        next_cycle();
`else
        do_txn('{1'b0, 3'd2, 32'h0000_0102, 32'h0, 32'h0BAD_F00D, 0, 1'b1, 4'b1111, 32'h0000_0100, 32'h0, 32'h0BAD_F00D});
`endif

        // Random transactions against the reference model
        for (int i = 0; i < 200; i++) begin
            r.we    = 1'($urandom_range(0, 1));
            r.size  = 3'($urandom_range(0, 7));
            if (r.we && (r.size == 3'd4 || r.size == 3'd5)) r.size = r.size - 3'd4;
            r.addr  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            if (r.size[1:0] == 2'b01) r.addr = r.addr & 32'hFFFF_FFFE;
            else if (r.size[1:0] != 2'b00) r.addr = r.addr & 32'hFFFF_FFFC;
`endif
            r.wd    = $urandom;
            r.rdata = $urandom;
            r.delay = int'($urandom_range(0, 3));
            r.gap   = 1'($urandom_range(0, 1));
            model(r.size, r.addr, r.wd, r.rdata, r.be, r.maddr, r.mwd, r.rd);
            do_txn(r);
        end

        core_req_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        chk("final_hold", core_rd_o, hold_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load-store unit between the single-cycle `riscv_core` data port and the data memory. It registers each core memory request, drives a word-aligned memory transaction with byte enables, and holds `core_stall_o` until the memory returns `mem_ready_i`. On loads it extracts the addressed byte or halfword and sign- or zero-extends it. It is the direct consumer of the core's `mem_req_o`/`mem_we_o`/`mem_size_o`/`mem_addr_o`/`mem_wd_o` and the producer of the core's `stall_i`/`mem_rd_i`.

## Interface
No parameters.

Ports:
- Clocking and reset:
  - `clk_i` in, 1: single clock; all state on rising edge.
  - `rst_i` in, 1: synchronous, active-high reset.
- Core side:
  - `core_req_i` in, 1: access request from the core.
  - `core_we_i` in, 1: 1 = store, 0 = load.
  - `core_size_i` in, 3: funct3 encoding: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
  - `core_addr_i` in, 32: byte address.
  - `core_wd_i` in, 32: store data, right-aligned.
  - `core_rd_o` out, 32: load result, extended.
  - `core_stall_o` out, 1: core must hold PC and inputs.
  - `core_misalign_o` out, 1: misaligned-access pulse. Always present; see Configuration.
- Memory side:
  - `mem_req_o` out, 1: memory transaction valid.
  - `mem_we_o` out, 1: write strobe.
  - `mem_be_o` out, 4: byte-lane enables.
  - `mem_addr_o` out, 32: word address, bits [1:0] = 0.
  - `mem_wd_o` out, 32: lane-replicated write data.
  - `mem_rd_i` in, 32: read word; valid in the cycle `mem_ready_i` = 1.
  - `mem_ready_i` in, 1: transaction complete.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE with `core_req_i` = 1:
  - Capture `we`, `size`, `addr[1:0]`, word address, byte enables and formatted write data into registers.
  - Go to ACCESS.
- ACCESS:
  - `mem_req_o` = 1 and all `mem_*` outputs come from the capture registers.
  - Hold until `mem_ready_i` = 1, then return to IDLE.
- Stall: `core_stall_o = core_req_i & ~(state==ACCESS & mem_ready_i)`. This is combinational, so the core is stalled in the issue cycle.
- Byte enables:
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
  - Loads use the same mask as stores.
- Write data:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd` unchanged.
- Load extraction from `mem_rd_i`, using the registered offset:
  - B: byte lane `addr[1:0]`, sign-extended.
  - BU: same lane, zero-extended.
  - H: half `addr[1]`, sign-extended.
  - HU: same half, zero-extended.
  - W: full word.
- `core_rd_o` source:
  - Extracted value, combinationally, in the completion cycle (ACCESS & `mem_ready_i` & load).
  - Otherwise the last completed load value, which is held in a register.
- Undefined sizes 3, 6 and 7 behave as W.
- Stores never change the held `core_rd_o` value.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_req_o`, `mem_we_o`, `core_misalign_o` = 0.
  - `mem_be_o` = 0.
  - `mem_addr_o`, `mem_wd_o`, `core_rd_o` = 0.
  - `core_stall_o` follows its equation, so it is 1 whenever `core_req_i` = 1 after reset.
- Minimum access: 2 cycles.
  - Cycle N: IDLE issue, stall = 1.
  - Cycle N+1: ACCESS with `mem_ready_i` = 1, stall = 0, core retires at the N+1 edge.
- Each extra cycle of `mem_ready_i` = 0 adds one stall cycle. `mem_*` outputs stay stable throughout ACCESS.
- Back-to-back: a new `core_req_i` in the cycle after completion is issued normally. The request held during the completion cycle is not re-issued.
- `mem_ready_i` in IDLE is ignored.
- `rst_i` during ACCESS: IDLE at next edge; `mem_req_o` = 0 and the pending response is discarded.
- `rst_i` has priority over all events.

## Configuration
Macro `LSU_MISALIGN_TRAP_EN`.

Defined:
- An H/HU access with `addr[0]` = 1, or a W access with `addr[1:0]` ≠ 0, is not issued.
- The FSM stays in IDLE.
- `core_misalign_o` = 1 combinationally in that cycle.
- `core_stall_o` = 0 and `core_rd_o` holds its previous value.

Not defined:
- `core_misalign_o` is tied 0.
- Misaligned low address bits are ignored: H uses `addr[1]`, W uses lane 0.
- The access is performed.

## Test plan
- Reset with `core_req_i` = 0 -> every output is 0 except `core_stall_o`, which is also 0 because it follows its equation.
- SW addr 0x100, wd 0xDEADBEEF, ready in first ACCESS cycle -> stall for 1 cycle; `mem_addr_o` 0x100, `mem_be_o` 1111, `mem_wd_o` 0xDEADBEEF, `mem_we_o` 1.
- SB addr 0x103, wd 0x000000A5 -> `mem_be_o` 1000, `mem_wd_o` 0xA5A5A5A5, `mem_addr_o` 0x100.
- LB and LBU at addr 0x102, `mem_rd_i` 0x12F03456 ->
  - `core_rd_o` 0xFFFFFFF0 for LB and 0x000000F0 for LBU in the completion cycle.
  - The value is held afterwards.
- LH addr 0x202, `mem_ready_i` delayed 3 cycles, `mem_rd_i` 0x80010000 ->
  - Stall lasts 4 cycles and `mem_*` outputs stay stable.
  - `core_rd_o` = 0xFFFF8001.
  - `rst_i` asserted in the 2nd ACCESS cycle instead -> IDLE next cycle, `mem_req_o` 0.
- LW addr 0x102:
  - With `LSU_MISALIGN_TRAP_EN`: `core_misalign_o` = 1, no `mem_req_o`, stall 0.
  - Without it: `mem_addr_o` 0x100, normal LW.
